pixel_xform_dma: RTL and testbench
==================================

Name: pixel_xform_dma

Overview:
Parametrised successor to the single-pixel transform peripheral. It is an Avalon-MM slave (CSR) plus Avalon-MM master that streams a pixel buffer from source memory, transforms LANES = DATA_W/PIX_W pixels per word in a selectable mode, and writes the results to a destination buffer. It sits in the Platform Designer system between the Nios II and on-chip SDRAM/SRAM. The CPU programs it and then blocks on a status read.

Parameters:
DATA_W, 32, master/slave data width; must be a multiple of PIX_W
PIX_W, 8, bits per pixel lane
ADDR_W, 32, master byte-address width
LEN_W, 16, width of the word-count register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
slave_address  in  3  CSR word offset
slave_read  in  1  CSR read strobe
slave_write  in  1  CSR write strobe
slave_writedata  in  32  CSR write data
slave_readdata  out  32  CSR read data
slave_waitrequest  out  1  CSR stall
master_address  out  ADDR_W  byte address
master_read  out  1  read request
master_readdata  in  DATA_W  read data
master_readdatavalid  in  1  read data valid
master_write  out  1  write request
master_writedata  out  DATA_W  write data
master_waitrequest  in  1  master stall

Behaviour:
- Reset: all outputs 0. State IDLE. CSRs 0. done flag 0.
- CSR map: 0 start/blocking status, 1 SRC byte addr, 2 DST byte addr, 3 LEN in words, 4 MODE[2:0], 5 PARAM[PIX_W-1:0], 6 non-blocking status {30'b0, done, busy}.
- Writes to offset 0 with any data: start if IDLE, otherwise ignored.
- Writes to offsets 1-5 while busy: ignored. Offset 6 and offsets 7+ are read-only; writes to them are ignored.
- A read of offset 0 asserts slave_waitrequest until state is IDLE, then returns 0.
- All other reads: waitrequest low, readdata valid in the same cycle. Offsets 1-5 read back the stored value; offset 7 reads 0.
- Start latches SRC/DST/LEN into working counters, clears done, and goes to RD_REQ. LEN = 0 goes straight to DONE with no bus activity.
- RD_REQ: master_read = 1 and master_address = src_ptr, held until waitrequest is low in a sampled cycle. Then go to RD_WAIT with master_read = 0.
- RD_WAIT: on readdatavalid, register the transformed word and go to WR_REQ. At most one read is outstanding.
- WR_REQ: master_write = 1, address = dst_ptr, writedata = transformed word, held stable until waitrequest is low.
- On write acceptance: src_ptr += DATA_W/8, dst_ptr += DATA_W/8, remaining -= 1. If remaining reaches 0 go to DONE, else go to RD_REQ.
- DONE: set done = 1 and go to IDLE on the next cycle. done stays set until the next start.
- Transform, applied independently per lane p (unsigned, PIX_W bits, MAX = 2^PIX_W - 1):
  - mode 0: pass.
  - mode 1: MAX - p.
  - mode 2: p >= PARAM ? MAX : 0.
  - mode 3: min(p + PARAM, MAX) (saturating add).
  - mode 4: max(p - PARAM, 0) (saturating subtract).
  - modes 5-7: pass.
- Lane i occupies bits [i*PIX_W +: PIX_W]. No carry crosses lanes.
- Address arithmetic wraps modulo 2^ADDR_W. LEN is unsigned, up to 2^LEN_W - 1.
- Latency per word: 1 read-issue cycle + memory latency + 1 register cycle + 1 write cycle, minimum 3 cycles with zero wait states.
- Reset mid-operation: immediately return to IDLE and drop master_read/master_write. No further bus requests. CSRs clear.
- CSR reads of offset 6 are allowed during operation and do not disturb it.

Test Plan:
- Pass-through: SRC=0x1000, DST=0x2000, LEN=4, MODE=0; memory words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> identical 4 words at 0x2000-0x200C; offset-0 read stalls then returns 0; offset 6 reads 0x2.
- Invert/threshold: word 0x00FF7F80. MODE=1 -> 0xFF00807F. MODE=2 with PARAM=0x80 -> 0x00FF00FF.
- Saturation: word 0xF0100501, PARAM=0x20. MODE=3 -> 0xFF302521. MODE=4 -> 0xD0000000. Verify no lane-to-lane carry.
- Stalls: a random master_waitrequest pattern plus a readdatavalid delay of 0-5 cycles, LEN=16 -> all 16 words correct; address/writedata held stable while stalled; never more than one outstanding read.
- Edge cases: LEN=0 -> done with no master_read/master_write; writes to SRC and a second start while busy are ignored (original transfer completes unchanged).
- Reset mid-transfer: assert rst_n low during word 3 of LEN=8 -> master_read/master_write = 0 next edge, offset 6 reads 0. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/pixel_xform_dma_if.sv
// Bus bundle for pixel_xform_dma: CSR slave side and memory master side.
// The DUT takes the same bundle twice, once through each modport.
interface pixel_xform_dma_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // CSR slave port
  logic [2:0]        slave_address;
  logic              slave_read;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic [31:0]       slave_readdata;
  logic              slave_waitrequest;

  // memory master port
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic              master_waitrequest;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
    output slave_readdata, slave_waitrequest
  );

  modport master (
    output master_address, master_read, master_write, master_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest
  );
endinterface

// File: rtl/pixel_xform_dma.sv
// pixel_xform_dma: CSR-programmed DMA that reads words from SRC, applies a
// per-lane pixel transform and writes them to DST. One read outstanding at
// a time; the CPU blocks on a read of CSR offset 0 until the engine is idle.
module pixel_xform_dma #(
  parameter int DATA_W = 32,   // must be a multiple of PIX_W
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  pixel_xform_dma_if.slave  csr,
  pixel_xform_dma_if.master mem
);
  localparam int LANES = DATA_W / PIX_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam logic [PIX_W-1:0]  MAX  = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, dst_reg, src_ptr_reg, dst_ptr_reg;
  logic [LEN_W-1:0]  len_reg, remain_reg;
  logic [2:0]        mode_reg;
  logic [PIX_W-1:0]  param_reg;
  logic [DATA_W-1:0] word_reg;
  logic              done_reg;

  logic              busy, start, cfg_wr;
  logic [DATA_W-1:0] xform;

  // DONE counts as busy so a start cannot slip in before done is set
  assign busy   = (state_reg != S_IDLE);
  assign start  = csr.slave_write && (csr.slave_address == 3'd0) && !busy;
  assign cfg_wr = csr.slave_write && !busy;

  // per-lane transform of the incoming read word; lanes never interact
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] p, q;
      logic [PIX_W:0]   sum;
      assign p   = mem.master_readdata[gi*PIX_W +: PIX_W];
      assign sum = {1'b0, p} + {1'b0, param_reg};
      // select the lane result by mode; unused modes pass through
      always_comb begin
        case (mode_reg)
          3'd1:    q = MAX - p;
          3'd2:    q = (p >= param_reg) ? MAX : '0;
          3'd3:    q = sum[PIX_W] ? MAX : sum[PIX_W-1:0];
          3'd4:    q = (p >= param_reg) ? (p - param_reg) : '0;
          default: q = p;
        endcase
      end
      assign xform[gi*PIX_W +: PIX_W] = q;
    end
  endgenerate

  // CSR read mux; offset 0 only completes once the engine is idle
  always_comb begin
    csr.slave_readdata = '0;
    if (csr.slave_read) begin
      case (csr.slave_address)
        3'd1:    csr.slave_readdata = 32'(src_reg);
        3'd2:    csr.slave_readdata = 32'(dst_reg);
        3'd3:    csr.slave_readdata = 32'(len_reg);
        3'd4:    csr.slave_readdata = 32'(mode_reg);
        3'd5:    csr.slave_readdata = 32'(param_reg);
        3'd6:    csr.slave_readdata = 32'({done_reg, busy});
        default: csr.slave_readdata = '0;
      endcase
    end
  end

  assign csr.slave_waitrequest = csr.slave_read && (csr.slave_address == 3'd0) && busy;

  // master outputs decode straight from the registered state
  assign mem.master_read      = (state_reg == S_RD_REQ);
  assign mem.master_write     = (state_reg == S_WR_REQ);
  assign mem.master_address   = (state_reg == S_RD_REQ) ? src_ptr_reg :
                                (state_reg == S_WR_REQ) ? dst_ptr_reg : '0;
  assign mem.master_writedata = (state_reg == S_WR_REQ) ? word_reg : '0;

  // next-state logic for the transfer sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = (len_reg == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (!mem.master_waitrequest) state_next = S_RD_WAIT;
      S_RD_WAIT: if (mem.master_readdatavalid) state_next = S_WR_REQ;
      S_WR_REQ:  if (!mem.master_waitrequest)
                   state_next = (remain_reg == LEN_W'(1)) ? S_DONE : S_RD_REQ;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // configuration registers, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      mode_reg  <= '0;
      param_reg <= '0;
    end else if (cfg_wr) begin
      case (csr.slave_address)
        3'd1:    src_reg   <= ADDR_W'(csr.slave_writedata);
        3'd2:    dst_reg   <= ADDR_W'(csr.slave_writedata);
        3'd3:    len_reg   <= LEN_W'(csr.slave_writedata);
        3'd4:    mode_reg  <= csr.slave_writedata[2:0];
        3'd5:    param_reg <= csr.slave_writedata[PIX_W-1:0];
        default: ;
      endcase
    end
  end

  // working pointers, word buffer and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      remain_reg  <= '0;
      word_reg    <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          src_ptr_reg <= src_reg;
          dst_ptr_reg <= dst_reg;
          remain_reg  <= len_reg;
          done_reg    <= 1'b0;
        end
        S_RD_WAIT: if (mem.master_readdatavalid) word_reg <= xform;
        S_WR_REQ: if (!mem.master_waitrequest) begin
          src_ptr_reg <= src_ptr_reg + STEP;
          dst_ptr_reg <= dst_ptr_reg + STEP;
          remain_reg  <= remain_reg - LEN_W'(1);
        end
        S_DONE: done_reg <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_xform_dma.sv
// Directed bench for pixel_xform_dma: CSR programming, transform modes,
// memory stalls, busy-write protection and reset in the middle of a transfer.
`timescale 1ns/1ps
module tb_pixel_xform_dma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_xform_dma_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  pixel_xform_dma #(.DATA_W(32), .PIX_W(8), .ADDR_W(32), .LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .csr   (bus),
    .mem   (bus)
  );

  int total = 0;
  int bad = 0;
  int proto_err = 0;
  int rd_count = 0;
  int wr_count = 0;
  bit stall_en = 1'b0;
  int delay_max = 0;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1;
    @(negedge clk);
    bus.slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d, output int stalls, output bit to);
    @(negedge clk);
    bus.slave_address = a; bus.slave_read = 1'b1;
    stalls = 0;
    #1;
    while (bus.slave_waitrequest && stalls < 5000) begin
      @(negedge clk); #1; stalls++;
    end
    to = bus.slave_waitrequest;
    d = bus.slave_readdata;
    @(negedge clk);
    bus.slave_read = 1'b0;
  endtask

  task automatic program_csr(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                             input logic [31:0] mode, input logic [31:0] param);
    csr_write(3'd1, src); csr_write(3'd2, dst); csr_write(3'd3, len);
    csr_write(3'd4, mode); csr_write(3'd5, param);
  endtask

  task automatic wait_idle(output int stalls);
    logic [31:0] d; bit to;
    csr_read(3'd0, d, stalls, to);
    check("blk_timeout", 32'(to), 32'd0);
    check("blk_status", d, 32'd0);
  endtask

  task automatic start_and_wait(output int stalls);
    rd_count = 0; wr_count = 0; proto_err = 0;
    csr_write(3'd0, 32'd1);
    wait_idle(stalls);
  endtask

  // Avalon memory model: random stalls, variable read latency, protocol checks
  initial begin : responder
    bit pend = 0, rvld = 0, acc_rd = 0, acc_wr = 0, st_rd = 0, st_wr = 0;
    int cnt = 0;
    logic [31:0] rdat = 0, a_rd = 0, a_wr = 0, d_wr = 0;
    bus.master_waitrequest = 1'b0; bus.master_readdatavalid = 1'b0; bus.master_readdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; rvld = 0; acc_rd = 0; acc_wr = 0; st_rd = 0; st_wr = 0;
      end else begin
        if (rvld) pend = 0;
        if (acc_rd) begin
          pend = 1; cnt = $urandom_range(0, delay_max); rdat = mem_rd(a_rd); rd_count++;
        end
        if (acc_wr) begin mem_model[a_wr] = d_wr; wr_count++; end
        if (st_rd && (!bus.master_read || bus.master_address !== a_rd)) proto_err++;
        if (st_wr && (!bus.master_write || bus.master_address !== a_wr || bus.master_writedata !== d_wr)) proto_err++;
        if (bus.master_read && pend) proto_err++;
        if (bus.master_read && bus.master_write) proto_err++;
      end
      bus.master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      rvld = 0;
      if (pend && rst_n) begin
        if (cnt == 0) rvld = 1; else cnt--;
      end
      bus.master_readdatavalid = rvld;
      bus.master_readdata = rvld ? rdat : 32'hA5A5A5A5;
      acc_rd = rst_n && bus.master_read && !bus.master_waitrequest;
      st_rd  = rst_n && bus.master_read && bus.master_waitrequest;
      a_rd   = bus.master_address;
      acc_wr = rst_n && bus.master_write && !bus.master_waitrequest;
      st_wr  = rst_n && bus.master_write && bus.master_waitrequest;
      a_wr   = bus.master_address;
      d_wr   = bus.master_writedata;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] d, w;
    int stalls, n;
    bit to;
    bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0; bus.slave_writedata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mread", 32'(bus.master_read), 32'd0);
    check("rst_mwrite", 32'(bus.master_write), 32'd0);
    check("rst_maddr", bus.master_address, 32'd0);
    check("rst_mwdata", bus.master_writedata, 32'd0);
    check("rst_swait", 32'(bus.slave_waitrequest), 32'd0);
    rst_n = 1'b1;
    for (int a = 1; a <= 7; a++) begin
      csr_read(3'(a), d, stalls, to);
      check($sformatf("rst_csr%0d", a), d, 32'd0);
    end

    // pass-through, LEN=4
    mem_model[32'h1000] = 32'h00112233; mem_model[32'h1004] = 32'h44556677;
    mem_model[32'h1008] = 32'h8899AABB; mem_model[32'h100C] = 32'hCCDDEEFF;
    program_csr(32'h1000, 32'h2000, 32'd4, 32'd0, 32'd0);
    csr_read(3'd1, d, stalls, to); check("rb_src", d, 32'h1000);
    csr_read(3'd3, d, stalls, to); check("rb_len", d, 32'd4);
    start_and_wait(stalls);
    check("pass_stalled", 32'(stalls > 0), 32'd1);
    check("pass_w0", mem_rd(32'h2000), 32'h00112233);
    check("pass_w1", mem_rd(32'h2004), 32'h44556677);
    check("pass_w2", mem_rd(32'h2008), 32'h8899AABB);
    check("pass_w3", mem_rd(32'h200C), 32'hCCDDEEFF);
    check("pass_rds", 32'(rd_count), 32'd4);
    check("pass_proto", 32'(proto_err), 32'd0);
    csr_read(3'd6, d, stalls, to); check("pass_status", d, 32'h2);

    // invert, threshold, reserved mode
    mem_model[32'h3000] = 32'h00FF7F80;
    program_csr(32'h3000, 32'h4000, 32'd1, 32'd1, 32'd0); start_and_wait(stalls);
    check("invert", mem_rd(32'h4000), 32'hFF00807F);
    program_csr(32'h3000, 32'h4004, 32'd1, 32'd2, 32'h80); start_and_wait(stalls);
    check("threshold", mem_rd(32'h4004), 32'h00FF00FF);
    program_csr(32'h3000, 32'h4008, 32'd1, 32'd7, 32'h80); start_and_wait(stalls);
    check("mode7_pass", mem_rd(32'h4008), 32'h00FF7F80);

    // saturating add / subtract, no cross-lane carry
    mem_model[32'h3010] = 32'hF0100501;
    program_csr(32'h3010, 32'h4010, 32'd1, 32'd3, 32'h20); start_and_wait(stalls);
    check("sat_add", mem_rd(32'h4010), 32'hFF302521);
    program_csr(32'h3010, 32'h4014, 32'd1, 32'd4, 32'h20); start_and_wait(stalls);
    check("sat_sub", mem_rd(32'h4014), 32'hD0000000);

    // random stalls and read latency, LEN=16, invert mode
    for (int i = 0; i < 16; i++) mem_model[32'h5000 + 32'(4*i)] = (32'(i) * 32'h11111111) ^ 32'h0F1E2D3C;
    stall_en = 1'b1; delay_max = 5;
    program_csr(32'h5000, 32'h6000, 32'd16, 32'd1, 32'd0); start_and_wait(stalls);
    for (int i = 0; i < 16; i++) begin
      w = ~((32'(i) * 32'h11111111) ^ 32'h0F1E2D3C);
      check($sformatf("stall_w%0d", i), mem_rd(32'h6000 + 32'(4*i)), w);
    end
    check("stall_rds", 32'(rd_count), 32'd16);
    check("stall_wrs", 32'(wr_count), 32'd16);
    check("stall_proto", 32'(proto_err), 32'd0);

    // LEN=0: done without any bus traffic
    stall_en = 1'b0; delay_max = 0;
    program_csr(32'h6800, 32'h7000, 32'd0, 32'd0, 32'd0); start_and_wait(stalls);
    check("len0_rds", 32'(rd_count), 32'd0);
    check("len0_wrs", 32'(wr_count), 32'd0);
    csr_read(3'd6, d, stalls, to); check("len0_status", d, 32'h2);

    // writes and a second start while busy are ignored
    stall_en = 1'b1; delay_max = 3;
    program_csr(32'h1000, 32'h7100, 32'd4, 32'd0, 32'd0);
    rd_count = 0; wr_count = 0; proto_err = 0;
    csr_write(3'd0, 32'd1);
    csr_write(3'd1, 32'h9000);
    csr_write(3'd0, 32'd1);
    csr_write(3'd3, 32'd9);
    csr_read(3'd6, d, stalls, to); check("busy_status", d, 32'h1);
    wait_idle(stalls);
    check("busy_w0", mem_rd(32'h7100), 32'h00112233);
    check("busy_w3", mem_rd(32'h710C), 32'hCCDDEEFF);
    check("busy_rds", 32'(rd_count), 32'd4);
    check("busy_wrs", 32'(wr_count), 32'd4);
    csr_read(3'd1, d, stalls, to); check("busy_src", d, 32'h1000);
    csr_read(3'd3, d, stalls, to); check("busy_len", d, 32'd4);

    // reset during word 3 of LEN=8
    stall_en = 1'b0; delay_max = 2;
    for (int i = 0; i < 8; i++) mem_model[32'h8000 + 32'(4*i)] = 32'h01010101 * 32'(i + 1);
    program_csr(32'h8000, 32'h8800, 32'd8, 32'd0, 32'd0);
    rd_count = 0; wr_count = 0; proto_err = 0;
    csr_write(3'd0, 32'd1);
    n = 0;
    while (rd_count < 3 && n < 2000) begin @(negedge clk); n++; end
    check("mid_reach3", 32'(rd_count >= 3), 32'd1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_mread", 32'(bus.master_read), 32'd0);
    check("mid_mwrite", 32'(bus.master_write), 32'd0);
    csr_read(3'd6, d, stalls, to); check("mid_status", d, 32'd0);
    csr_read(3'd1, d, stalls, to); check("mid_src", d, 32'd0);
    n = wr_count;
    repeat (5) @(negedge clk);
    check("mid_quiet", 32'(wr_count), 32'(n));
    rst_n = 1'b1;

    // fresh start after reset
    mem_model[32'h3014] = 32'h30405060;
    program_csr(32'h3010, 32'h4020, 32'd2, 32'd4, 32'h20); start_and_wait(stalls);
    check("post_w0", mem_rd(32'h4020), 32'hD0000000);
    check("post_w1", mem_rd(32'h4024), 32'h10203040);
    check("post_proto", 32'(proto_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
